// File: rtl/bp_nonsynth_watchdog_pkg.sv
// bp_nonsynth_watchdog_pkg
//   Shared types and configuration helpers for the multi-core nonsynth watchdog.
//   It also defines the elaboration-time check that heartbeat_instr_p is at least num_core_p.
`ifndef BP_NONSYNTH_WATCHDOG_PKG_SV
`define BP_NONSYNTH_WATCHDOG_PKG_SV

// This check guarantees at most one heartbeat per cycle, because at most num_core_p
// instructions can retire in a single cycle.
`define BP_NONSYNTH_WATCHDOG_CHECK_HB(hb_mp, nc_mp) \
   if ((hb_mp) < (nc_mp)) begin : hb_check \
      $error("bp_nonsynth_watchdog: heartbeat_instr_p must be >= num_core_p"); \
   end

package bp_nonsynth_watchdog_pkg;

   // Processor configurations. They are reduced to the fields the watchdog consumes.
   typedef enum logic [1:0] {
      e_bp_default_cfg,
      e_bp_dual_core_cfg,
      e_bp_quad_core_cfg
   } bp_params_e;

   // Per-lane detector state. e_stall and e_halt are terminal until reset.
   typedef enum logic [1:0] {e_run, e_stall, e_halt} bp_watchdog_state_e;

   // Virtual address width shared by every configuration above.
   localparam int bp_vaddr_width_gp = 39;

   // Number of cores for a given configuration.
   function automatic int bp_num_core(bp_params_e cfg);
      case (cfg)
         e_bp_dual_core_cfg: return 2;
         e_bp_quad_core_cfg: return 4;
         default:            return 1;
      endcase
   endfunction

endpackage

`endif

// File: rtl/bp_nonsynth_watchdog_lane.sv
// bp_nonsynth_watchdog_lane
//   Stall/halt detector for one core. It tracks how long the next PC has stayed frozen.
//   - A stall is declared when the next PC is frozen for stall_cycles_p cycles outside WFI.
//   - A halt is declared when halt_cycles_p instructions retire while the next PC is frozen
//     (a jump-to-self).
//   Both flags are sticky until reset.
module bp_nonsynth_watchdog_lane
   import bp_nonsynth_watchdog_pkg::*;
 #(parameter int vaddr_width_p  = 39
   , parameter int stall_cycles_p = 8
   , parameter int halt_cycles_p  = 4
   )
  (input  logic                     clk_i
   , input  logic                     reset_i
   , input  logic                     wfi_i
   , input  logic [vaddr_width_p-1:0] npc_i
   , input  logic                     instret_i
   , output logic                     stall_o
   , output logic                     halt_o
   );

   localparam int stall_width_lp = $clog2(stall_cycles_p+1);
   localparam int halt_width_lp  = $clog2(halt_cycles_p+1);
   localparam logic [stall_width_lp-1:0] stall_max_lp = stall_width_lp'(stall_cycles_p);
   localparam logic [halt_width_lp-1:0]  halt_max_lp  = halt_width_lp'(halt_cycles_p);

   bp_watchdog_state_e          state_r;
   logic [vaddr_width_p-1:0]    npc_r;
   logic [stall_width_lp-1:0]   stall_cnt_r;
   logic [halt_width_lp-1:0]    halt_cnt_r;
   logic                        npc_change;
   logic                        cnt_clear;

   assign npc_change = (npc_i != npc_r);

   // Any sign of progress (a new PC, or sleeping in WFI) restarts both counters.
   // A lane that has already reached a verdict keeps its counters at zero.
   assign cnt_clear = reset_i | npc_change | wfi_i | (state_r != e_run);

   // Track the previous next PC every cycle, including during reset.
   always_ff @(posedge clk_i) begin
      npc_r <= npc_i;
   end

   // Count frozen cycles, saturating at the stall threshold.
   always_ff @(posedge clk_i) begin
      if (cnt_clear)
         stall_cnt_r <= '0;
      else if (stall_cnt_r != stall_max_lp)
         stall_cnt_r <= stall_cnt_r + stall_width_lp'(1);
   end

   // Count retirements while frozen, saturating at the halt threshold.
   always_ff @(posedge clk_i) begin
      if (cnt_clear)
         halt_cnt_r <= '0;
      else if (instret_i && (halt_cnt_r != halt_max_lp))
         halt_cnt_r <= halt_cnt_r + halt_width_lp'(1);
   end

   // Verdict FSM with registered flags. Halt wins when both thresholds are met together.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_run;
         stall_o <= 1'b0;
         halt_o  <= 1'b0;
      end else begin
         case (state_r)
            e_run: begin
               if (halt_cnt_r == halt_max_lp) begin
                  state_r <= e_halt;
                  halt_o  <= 1'b1;
               end else if (stall_cnt_r == stall_max_lp) begin
                  state_r <= e_stall;
                  stall_o <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // An unknown next PC outside reset means the core model itself is broken.
   always @(posedge clk_i) begin
      if (!reset_i && $isunknown(npc_i))
         $fatal(1, "[BSG-FATAL] watchdog lane: npc_i contains X");
   end

endmodule

// File: rtl/bp_nonsynth_watchdog_mc.sv
// bp_nonsynth_watchdog_mc
//   Multi-core nonsynth watchdog. It instantiates one stall/halt lane per core and provides:
//   - a saturating total of retired instructions,
//   - a heartbeat pulse every heartbeat_instr_p retirements,
//   - all_halt_o once every core has halted.
//   When fail_on_stall_p is set, the simulation finishes at the negedge after a stall flag rises.
//   Optional feature macro: BP_NONSYNTH_WATCHDOG_TRACE_EN. When it is defined, halt, stall and
//   heartbeat messages are printed at negedge.
module bp_nonsynth_watchdog_mc
   import bp_nonsynth_watchdog_pkg::*;
 #(parameter bp_params_e bp_params_p     = e_bp_default_cfg
   , parameter int stall_cycles_p        = 100000
   , parameter int halt_cycles_p         = 10
   , parameter int heartbeat_instr_p     = 100000
   , parameter bit fail_on_stall_p       = 1'b1
   , localparam int num_core_p           = bp_num_core(bp_params_p)
   , localparam int vaddr_width_p        = bp_vaddr_width_gp
   , localparam int max_instr_lp         = 2**30
   , localparam int instr_width_lp       = $clog2(max_instr_lp+1)
   )
  (input  logic                                clk_i
   , input  logic                                reset_i
   , input  logic [num_core_p-1:0]               wfi_i
   , input  logic [num_core_p*vaddr_width_p-1:0] npc_i
   , input  logic [num_core_p-1:0]               instret_i
   , output logic [num_core_p-1:0]               stall_o
   , output logic [num_core_p-1:0]               halt_o
   , output logic                                all_halt_o
   , output logic [instr_width_lp-1:0]           instr_total_o
   , output logic                                heartbeat_v_o
   );

   `BP_NONSYNTH_WATCHDOG_CHECK_HB(heartbeat_instr_p, num_core_p)

   localparam int inc_width_lp   = $clog2(num_core_p+1);
   localparam int total_width_lp = instr_width_lp + 1;
   localparam int hb_width_lp    = $clog2(heartbeat_instr_p + num_core_p + 1);
   localparam logic [total_width_lp-1:0] max_instr_ext_lp = total_width_lp'(max_instr_lp);
   localparam logic [hb_width_lp-1:0]    hb_period_lp     = hb_width_lp'(heartbeat_instr_p);

   logic [inc_width_lp-1:0]   inc;
   logic [total_width_lp-1:0] total_sum;
   logic [hb_width_lp-1:0]    hb_acc_r;
   logic [hb_width_lp-1:0]    hb_sum;
   logic [num_core_p-1:0]     stall_r;

   // Per-core detectors.
   genvar gi;
   for (gi = 0; gi < num_core_p; gi++) begin : lane
      bp_nonsynth_watchdog_lane
       #(.vaddr_width_p  (vaddr_width_p)
         ,.stall_cycles_p (stall_cycles_p)
         ,.halt_cycles_p  (halt_cycles_p)
         )
       lane_inst
        (.clk_i      (clk_i)
         ,.reset_i   (reset_i)
         ,.wfi_i     (wfi_i[gi])
         ,.npc_i     (npc_i[gi*vaddr_width_p +: vaddr_width_p])
         ,.instret_i (instret_i[gi])
         ,.stall_o   (stall_o[gi])
         ,.halt_o    (halt_o[gi])
         );
   end

   // Retirements are counted on every lane, including lanes that have already halted.
   assign inc       = inc_width_lp'($countones(instret_i));
   assign total_sum = {1'b0, instr_total_o} + total_width_lp'(inc);
   assign hb_sum    = hb_acc_r + hb_width_lp'(inc);

   // Aggregate retired-instruction count, clamped at max_instr_lp.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         instr_total_o <= '0;
      else if (total_sum > max_instr_ext_lp)
         instr_total_o <= instr_width_lp'(max_instr_lp);
      else
         instr_total_o <= total_sum[instr_width_lp-1:0];
   end

   // Heartbeat accumulator. Any excess past the period carries into the next heartbeat.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hb_acc_r      <= '0;
         heartbeat_v_o <= 1'b0;
      end else if (hb_sum >= hb_period_lp) begin
         hb_acc_r      <= hb_sum - hb_period_lp;
         heartbeat_v_o <= 1'b1;
      end else begin
         hb_acc_r      <= hb_sum;
         heartbeat_v_o <= 1'b0;
      end
   end

   // all_halt_o follows the registered halt flags one cycle later.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         all_halt_o <= 1'b0;
      else
         all_halt_o <= &halt_o;
   end

   // Previous stall flags, used to detect rising edges at negedge.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         stall_r <= '0;
      else
         stall_r <= stall_o;
   end

`ifdef BP_NONSYNTH_WATCHDOG_TRACE_EN
   logic [num_core_p-1:0] halt_r;

   // Previous halt flags, used only to report halt rises.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         halt_r <= '0;
      else
         halt_r <= halt_o;
   end

   // Report each flag rise and each heartbeat half a cycle after it is registered.
   always @(negedge clk_i) begin
      for (int c = 0; c < num_core_p; c++) begin
         if (halt_o[c] && !halt_r[c])
            $display("[BSG-INFO] core %x halt", c);
         if (stall_o[c] && !stall_r[c])
            $display("[BSG-FAIL] core %x stalled %d cycles", c, stall_cycles_p);
      end
      if (heartbeat_v_o)
         $display("[BSG-INFO] %d instructions", instr_total_o);
   end
`endif

   // End the run at the negedge after a new stall is flagged, when the instance is configured to do so.
   always @(negedge clk_i) begin
      if (fail_on_stall_p && |(stall_o & ~stall_r))
         $finish;
   end

endmodule

// File: tb/tb_bp_nonsynth_watchdog_mc.sv
// tb_bp_nonsynth_watchdog_mc
//   Two-core bench: directed scenarios followed by a randomized phase.
//   Every cycle is compared against a reference model. The model treats each core as
//   "edges and retirements since it last showed progress", with unbounded counts and
//   threshold tests.
`timescale 1ns/1ps
module tb_bp_nonsynth_watchdog_mc;
   import bp_nonsynth_watchdog_pkg::*;

   localparam int     NC        = 2;
   localparam int     VW        = 39;
   localparam int     TW        = 31;
   localparam int     STALL_N   = 8;
   localparam int     HALT_N    = 4;
   localparam int     HB_N      = 4;
   localparam longint MAX_INSTR = 64'd1 << 30;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [NC-1:0]     wfi_i;
   logic [NC*VW-1:0]  npc_i;
   logic [NC-1:0]     instret_i;
   logic [NC-1:0]     stall_o;
   logic [NC-1:0]     halt_o;
   logic              all_halt_o;
   logic [TW-1:0]     instr_total_o;
   logic              heartbeat_v_o;

   always #5 clk_i = ~clk_i;

   bp_nonsynth_watchdog_mc
    #(.bp_params_p        (e_bp_dual_core_cfg)
      ,.stall_cycles_p    (STALL_N)
      ,.halt_cycles_p     (HALT_N)
      ,.heartbeat_instr_p (HB_N)
      ,.fail_on_stall_p   (1'b0)
      )
    dut
     (.clk_i          (clk_i)
      ,.reset_i       (reset_i)
      ,.wfi_i         (wfi_i)
      ,.npc_i         (npc_i)
      ,.instret_i     (instret_i)
      ,.stall_o       (stall_o)
      ,.halt_o        (halt_o)
      ,.all_halt_o    (all_halt_o)
      ,.instr_total_o (instr_total_o)
      ,.heartbeat_v_o (heartbeat_v_o)
      );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model state.
   logic [VW-1:0] cur_npc [NC];
   logic [VW-1:0] m_prev  [NC];
   int            m_edges [NC];
   int            m_rets  [NC];
   bit            m_stall [NC];
   bit            m_halt  [NC];
   longint        m_total;
   int            m_acc;
   bit            m_hb;
   bit            m_all;

   function automatic logic [VW-1:0] rand_npc();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[VW-1:0];
   endfunction

   // Apply one clock edge to the reference model. It uses the inputs sampled at that edge.
   function automatic void model_edge(bit rst, logic [NC-1:0] wfi, logic [NC-1:0] ret);
      int n;
      bit all_prev;
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            m_prev[c] = cur_npc[c]; m_edges[c] = 0; m_rets[c] = 0;
            m_stall[c] = 0; m_halt[c] = 0;
         end
         m_total = 0; m_acc = 0; m_hb = 0; m_all = 0;
         return;
      end
      all_prev = 1;
      for (int c = 0; c < NC; c++) all_prev &= m_halt[c];
      for (int c = 0; c < NC; c++) begin
         bit frozen;
         frozen = (cur_npc[c] == m_prev[c]) && !wfi[c];
         if (!m_stall[c] && !m_halt[c]) begin
            if (m_rets[c] >= HALT_N)        m_halt[c]  = 1;
            else if (m_edges[c] >= STALL_N) m_stall[c] = 1;
         end
         if (frozen) begin
            m_edges[c]++;
            m_rets[c] += int'(ret[c]);
         end else begin
            m_edges[c] = 0;
            m_rets[c]  = 0;
         end
         m_prev[c] = cur_npc[c];
      end
      n = $countones(ret);
      m_total = (m_total + n > MAX_INSTR) ? MAX_INSTR : m_total + n;
      m_acc += n;
      if (m_acc >= HB_N) begin m_acc -= HB_N; m_hb = 1; end
      else m_hb = 0;
      m_all = all_prev;
   endfunction

   // One transaction: drive the inputs, take one edge, then compare every output against the model.
   task automatic step(input bit rst, input logic [NC-1:0] wfi, input logic [NC-1:0] ret);
      logic [NC-1:0] es, eh;
      reset_i   = rst;
      wfi_i     = wfi;
      instret_i = ret;
      for (int c = 0; c < NC; c++) npc_i[c*VW +: VW] = cur_npc[c];
      @(posedge clk_i);
      model_edge(rst, wfi, ret);
      #1;
      cyc++;
      for (int c = 0; c < NC; c++) begin es[c] = m_stall[c]; eh[c] = m_halt[c]; end
      check("stall_o",       64'(stall_o),       64'(es));
      check("halt_o",        64'(halt_o),        64'(eh));
      check("all_halt_o",    64'(all_halt_o),    64'(m_all));
      check("heartbeat_v_o", 64'(heartbeat_v_o), 64'(m_hb));
      check("instr_total_o", 64'(instr_total_o), 64'(m_total));
      $display("cyc=%0d rst=%0b wfi=%b ret=%b stall=%b halt=%b all=%0b hb=%0b total=%0d",
               cyc, rst, wfi, ret, stall_o, halt_o, all_halt_o, heartbeat_v_o, instr_total_o);
   endtask

   initial begin
      int lat, lat_h, lat_a;
      bit seen;
      logic [NC-1:0] rw, rr;
      bit rrst;

      for (int c = 0; c < NC; c++) cur_npc[c] = rand_npc();
      step(1, '0, '0);
      step(1, '0, '0);
      check("reset_stall", 64'(stall_o), 0);
      check("reset_halt",  64'(halt_o), 0);
      check("reset_total", 64'(instr_total_o), 0);
      check("reset_hb",    64'(heartbeat_v_o), 0);

      // Heartbeat: two cores retiring every cycle produce a pulse every second cycle.
      for (int k = 1; k <= 10; k++) begin
         for (int c = 0; c < NC; c++) cur_npc[c] = rand_npc();
         step(0, '0, 2'b11);
         check("t4_hb_pattern", 64'(heartbeat_v_o), 64'((k % 2) == 0));
      end
      check("t4_total", 64'(instr_total_o), 20);

      // Stall: core0 is frozen at 0x80 with no retirement.
      cur_npc[0] = 39'h80;
      cur_npc[1] = rand_npc();
      step(0, '0, '0);
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         cur_npc[1] = rand_npc();
         step(0, '0, '0);
         if (stall_o[0]) begin lat = k; break; end
      end
      check("t1_stall_latency", 64'(lat), STALL_N + 1);

      step(1, '0, '0);
      check("t6_reset_clears_stall", 64'(stall_o), 0);

      // Halt: core1 retires every cycle at a frozen 0x100.
      cur_npc[0] = rand_npc();
      cur_npc[1] = 39'h100;
      step(0, '0, 2'b10);
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         cur_npc[0] = rand_npc();
         step(0, '0, 2'b10);
         if (halt_o[1]) begin lat = k; break; end
      end
      check("t2_halt_latency", 64'(lat), HALT_N + 1);
      check("t2_no_stall", 64'(stall_o[1]), 0);

      // All-halt: core0 halts later, and all_halt_o follows one cycle after it.
      cur_npc[0] = 39'h200;
      step(0, '0, 2'b11);
      lat_h = 99;
      lat_a = 99;
      for (int k = 1; k <= 20; k++) begin
         step(0, '0, 2'b11);
         if (halt_o[0] && lat_h == 99) lat_h = k;
         if (all_halt_o) begin lat_a = k; break; end
      end
      check("t3_halt0_latency", 64'(lat_h), HALT_N + 1);
      check("t3_all_halt_delay", 64'(lat_a - lat_h), 1);

      // Reset while flags are high.
      step(1, '0, '0);
      check("t6_reset_halt",  64'(halt_o), 0);
      check("t6_reset_all",   64'(all_halt_o), 0);
      check("t6_reset_total", 64'(instr_total_o), 0);

      // WFI: a frozen PC during WFI is not a stall, and detection starts once WFI drops.
      seen = 0;
      for (int k = 0; k < 3*STALL_N; k++) begin
         step(0, 2'b11, '0);
         if (|stall_o) seen = 1;
      end
      check("t5_no_stall_in_wfi", 64'(seen), 0);
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         step(0, '0, '0);
         if (stall_o[0]) begin lat = k; break; end
      end
      check("t5_stall_after_wfi", 64'(lat), STALL_N + 1);

      // Reset while stalled, then check that detection re-arms.
      step(1, '0, '0);
      check("t6_reset_stall2", 64'(stall_o), 0);
      lat = 99;
      for (int k = 1; k <= 20; k++) begin
         step(0, '0, '0);
         if (stall_o[1]) begin lat = k; break; end
      end
      check("t6_rearm_latency", 64'(lat), STALL_N + 1);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 500; k++) begin
         rrst = ($urandom_range(0, 63) == 0);
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 5) == 0) cur_npc[c] = rand_npc();
            rw[c] = ($urandom_range(0, 7) == 0);
            rr[c] = 1'($urandom_range(0, 1));
         end
         step(rrst, rw, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
